risc_mc_core: RTL and testbench

RISC_MC_CORE -- requirements
Module: risc_mc_core

---
 rtl/risc16_pkg.sv | 24 ++
 rtl/risc_mc_core_if.sv | 16 +
 rtl/risc_mc_alu.sv | 16 +
 rtl/risc_mc_core.sv | 110 +++++++++++
 tb/tb_risc_mc_core.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared opcode/state/ALU enums, instruction field positions and the halt encoding
// Used by risc_mc_core and risc_mc_alu.
package risc16_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR
  } opcode_e;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;
  typedef enum logic [1:0] {
    ALU_ADD, ALU_NAND, ALU_EQ, ALU_PASS
  } alu_fn_e;
  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int RA_HI = 12;
  localparam int RA_LO = 10;
  localparam int RB_HI = 9;
  localparam int RB_LO = 7;
  localparam int RC_HI = 2;
  localparam int RC_LO = 0;
  localparam int IMM7_HI = 6;
  localparam int IMM10_HI = 9;
  localparam logic [15:0] HALT_INSTR = 16'hE071;
endpackage

// File: rtl/risc_mc_core_if.sv
// risc_mc_core_if: single-port word-addressed memory bus
// master (core): drives mem_req/mem_we/mem_addr/mem_wdata, receives mem_rdata/mem_ready
// slave (memory): the reverse; a transfer completes on a rising edge with mem_req && mem_ready
interface risc_mc_core_if #(
  parameter int XLEN = 16,
  parameter int ADDR_W = 16
);
  logic mem_req;
  logic mem_we;
  logic mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/risc_mc_alu.sv
// risc_mc_alu: combinational ADD/NAND/EQ/PASS unit
// fn selects the operation; a, b operands; y result (EQ returns the compare flag in bit 0)
module risc_mc_alu
  import risc16_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  alu_fn_e fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  always_comb y = fn == ALU_ADD ? a + b :
                  fn == ALU_NAND ? ~(a & b) :
                  fn == ALU_EQ ? XLEN'(a == b) : b;
endmodule

// File: rtl/risc_mc_core.sv
// risc_mc_core: multicycle 16-bit-instruction RISC core (FETCH/DECODE/EXEC/MEM/WB)
// clk, reset (sync, active high); mem: memory bus master; curr_pc: pc of instruction in flight;
// curr_instr: latched instruction; retire: one pulse per completed instruction;
// halted: core stopped, only with RISC16_HALT_EN defined (tied 0 otherwise).
module risc_mc_core
  import risc16_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  risc_mc_core_if.master mem,
  output logic [ADDR_W-1:0] curr_pc,
  output logic [15:0] curr_instr,
  output logic retire,
  output logic halted
);
  state_e state;
  logic run;
  logic [XLEN-1:0] rf [8];
  logic [XLEN-1:0] a_val, b_val, c_val, res, mdata;
  logic [ADDR_W-1:0] pc, maddr, target;
  logic taken;
  opcode_e op;
  logic [2:0] ra, rb, rc;
  logic [XLEN-1:0] imm, lui, alu_a, alu_b, alu_y, wb_data;
  logic [ADDR_W-1:0] pc_inc, imm_pc, next_pc;
  logic is_mem, wb_en, is_halt;
  alu_fn_e fn;
  always_comb begin
    op = opcode_e'(curr_instr[OP_HI:OP_LO]);
    ra = curr_instr[RA_HI:RA_LO];
    rb = curr_instr[RB_HI:RB_LO];
    rc = curr_instr[RC_HI:RC_LO];
    imm = XLEN'($signed(curr_instr[IMM7_HI:0]));
    imm_pc = ADDR_W'($signed(curr_instr[IMM7_HI:0]));
    lui = XLEN'({curr_instr[IMM10_HI:0], 6'b0});
    pc_inc = pc + ADDR_W'(1);
    is_mem = op == OP_SW || op == OP_LW;
    fn = op == OP_NAND ? ALU_NAND : op == OP_BEQ ? ALU_EQ : op == OP_LUI ? ALU_PASS : ALU_ADD;
    alu_a = op == OP_BEQ ? a_val : b_val;
    alu_b = op == OP_BEQ ? b_val : (op == OP_ADD || op == OP_NAND) ? c_val : op == OP_LUI ? lui : imm;
    wb_en = !(op == OP_SW || op == OP_BEQ) && ra != 3'd0;
    wb_data = op == OP_LW ? mdata : op == OP_JALR ? XLEN'(pc_inc) : res;
    next_pc = op == OP_JALR ? ADDR_W'(b_val) : (op == OP_BEQ && taken) ? target : pc_inc;
  end
  risc_mc_alu #(.XLEN(XLEN)) u_alu (.fn(fn), .a(alu_a), .b(alu_b), .y(alu_y));
  // run stays low for the cycle after reset so no request is raised while reset is being released
  assign mem.mem_req = run && (state == S_FETCH || state == S_MEM);
  assign mem.mem_we = state == S_MEM && op == OP_SW;
  assign mem.mem_addr = state == S_FETCH ? pc : maddr;
  assign mem.mem_wdata = a_val;
  assign curr_pc = pc;
`ifdef RISC16_HALT_EN
  assign is_halt = curr_instr == HALT_INSTR;
  assign halted = state == S_HALT;
`else
  assign is_halt = 1'b0;
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      run <= 1'b0;
      pc <= RESET_PC;
      curr_instr <= '0;
      retire <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: if (run && mem.mem_ready) begin
          curr_instr <= mem.mem_rdata[15:0];
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_val <= rf[ra];
          b_val <= rf[rb];
          c_val <= rf[rc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res <= alu_y;
          maddr <= ADDR_W'(alu_y);
          taken <= alu_y[0];
          target <= pc_inc + imm_pc;
          state <= is_mem ? S_MEM : S_WB;
          retire <= !is_mem;
        end
        S_MEM: if (mem.mem_ready) begin
          mdata <= mem.mem_rdata;
          state <= S_WB;
          retire <= 1'b1;
        end
        S_WB: begin
          retire <= 1'b0;
          if (is_halt) state <= S_HALT;
          else begin
            if (wb_en) rf[ra] <= wb_data;
            pc <= next_pc;
            state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_mc_core.sv
// tb_risc_mc_core: directed programs on a 16-bit and a 32-bit core with store scoreboards
module tb_risc_mc_core;
  import risc16_pkg::*;
  localparam int DWAIT = 3;
  logic clk = 0;
  logic rst_a = 1;
  logic rst_b = 1;
  always #5 clk = ~clk;
  risc_mc_core_if #(.XLEN(16), .ADDR_W(16)) bus_a ();
  risc_mc_core_if #(.XLEN(32), .ADDR_W(16)) bus_b ();
  logic [15:0] pc_a, pc_b, instr_a, instr_b;
  logic ret_a, ret_b, halt_a, halt_b;
  risc_mc_core dut_a (.clk(clk), .reset(rst_a), .mem(bus_a), .curr_pc(pc_a), .curr_instr(instr_a), .retire(ret_a), .halted(halt_a));
  risc_mc_core #(.XLEN(32)) dut_b (.clk(clk), .reset(rst_b), .mem(bus_b), .curr_pc(pc_b), .curr_instr(instr_b), .retire(ret_b), .halted(halt_b));
  logic [15:0] imem_a [65536];
  logic [15:0] dmem_a [256];
  logic [31:0] imem_b [256];
  logic [31:0] dmem_b [256];
  logic [15:0] log_addr_a [64];
  logic [15:0] log_data_a [64];
  logic [15:0] log_addr_b [64];
  logic [31:0] log_data_b [64];
  int nlog_a = 0;
  int nlog_b = 0;
  int wcnt_a = 0;
  logic dreg_a, dreg_b;
  // data region 0x20-0x2F; accesses there on bus_a see DWAIT wait cycles
  assign dreg_a = bus_a.mem_addr[15:4] == 12'h002;
  assign dreg_b = bus_b.mem_addr[15:4] == 12'h002;
  assign bus_a.mem_rdata = dreg_a ? dmem_a[bus_a.mem_addr[7:0]] : imem_a[bus_a.mem_addr];
  assign bus_a.mem_ready = !dreg_a || wcnt_a == DWAIT;
  assign bus_b.mem_rdata = dreg_b ? dmem_b[bus_b.mem_addr[7:0]] : imem_b[bus_b.mem_addr[7:0]];
  assign bus_b.mem_ready = 1'b1;
  always @(posedge clk) begin
    if (bus_a.mem_req && bus_a.mem_ready) begin
      wcnt_a <= 0;
      if (bus_a.mem_we) begin
        dmem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
        log_addr_a[nlog_a[5:0]] <= bus_a.mem_addr;
        log_data_a[nlog_a[5:0]] <= bus_a.mem_wdata;
        nlog_a <= nlog_a + 1;
      end
    end else wcnt_a <= bus_a.mem_req ? wcnt_a + 1 : 0;
  end
  always @(posedge clk) begin
    if (bus_b.mem_req && bus_b.mem_we) begin
      dmem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
      log_addr_b[nlog_b[5:0]] <= bus_b.mem_addr;
      log_data_b[nlog_b[5:0]] <= bus_b.mem_wdata;
      nlog_b <= nlog_b + 1;
    end
  end
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_a [$];
  logic [47:0] exp_b [$];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] ri(input opcode_e op, input int ra, input int rb, input int imm);
    return {op, 3'(ra), 3'(rb), 7'(imm)};
  endfunction
  function automatic logic [15:0] rr(input opcode_e op, input int ra, input int rb, input int rc);
    return {op, 3'(ra), 3'(rb), 4'b0, 3'(rc)};
  endfunction
  function automatic logic [15:0] lu(input int ra, input int imm);
    return {OP_LUI, 3'(ra), 10'(imm)};
  endfunction
  initial begin
    int n;
    int lat;
    int nsave;
    logic [8:0] rmask;
    logic any_req;
    logic [31:0] ea;
    logic [47:0] eb;
    for (int i = 0; i < 65536; i++) imem_a[i] = 16'hC07F;
    for (int i = 0; i < 256; i++) imem_b[i] = 32'h0000C07F;
    imem_a[0] = ri(OP_ADDI, 1, 0, 5);
    imem_a[1] = rr(OP_ADD, 2, 1, 1);
    imem_a[2] = ri(OP_SW, 2, 0, 'h22); exp_a.push_back({16'h22, 16'd10});
    imem_a[3] = ri(OP_SW, 1, 0, 'h20); exp_a.push_back({16'h20, 16'd5});
    imem_a[4] = ri(OP_LW, 3, 0, 'h20);
    imem_a[5] = ri(OP_SW, 3, 0, 'h21); exp_a.push_back({16'h21, 16'd5});
    imem_a[6] = rr(OP_NAND, 4, 1, 2);
    imem_a[7] = ri(OP_SW, 4, 0, 'h23); exp_a.push_back({16'h23, 16'hFFFF});
    imem_a[8] = ri(OP_BEQ, 1, 3, 2);
    imem_a[9] = ri(OP_SW, 1, 0, 'h2F);
    imem_a[10] = ri(OP_SW, 1, 0, 'h2F);
    imem_a[11] = ri(OP_BEQ, 1, 2, 5);
    imem_a[12] = lu(5, 'h155);
    imem_a[13] = ri(OP_ADDI, 7, 0, 16);
    imem_a[14] = rr(OP_JALR, 6, 7, 0);
    imem_a[15] = ri(OP_SW, 1, 0, 'h2F);
    imem_a[16] = ri(OP_SW, 5, 0, 'h24); exp_a.push_back({16'h24, 16'h5540});
    imem_a[17] = ri(OP_SW, 6, 0, 'h25); exp_a.push_back({16'h25, 16'd15});
    imem_a[18] = ri(OP_ADDI, 7, 0, 21);
    imem_a[19] = rr(OP_JALR, 7, 7, 0);
    imem_a[20] = ri(OP_SW, 1, 0, 'h2F);
    imem_a[21] = ri(OP_SW, 7, 0, 'h26); exp_a.push_back({16'h26, 16'd20});
    imem_a[22] = ri(OP_ADDI, 0, 0, 5);
    imem_a[23] = ri(OP_SW, 0, 0, 'h27); exp_a.push_back({16'h27, 16'd0});
    imem_b[0] = 32'(ri(OP_ADDI, 1, 0, -1));
    imem_b[1] = 32'(rr(OP_NAND, 2, 1, 1));
    imem_b[2] = 32'(ri(OP_SW, 2, 0, 'h20)); exp_b.push_back({16'h20, 32'h0});
    imem_b[3] = 32'(ri(OP_ADDI, 0, 0, 5));
    imem_b[4] = 32'(ri(OP_SW, 0, 0, 'h21)); exp_b.push_back({16'h21, 32'h0});
    imem_b[5] = 32'(lu(3, 'h3FF));
    imem_b[6] = 32'(ri(OP_SW, 3, 0, 'h22)); exp_b.push_back({16'h22, 32'h0000FFC0});
    imem_b[7] = 32'(ri(OP_SW, 1, 0, 'h23)); exp_b.push_back({16'h23, 32'hFFFFFFFF});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus_a.mem_req, 0);
    check("rst_pc", pc_a, 0);
    check("rst_instr", instr_a, 0);
    check("rst_retire", ret_a, 0);
    check("rst_halted", halt_a, 0);
    @(posedge clk);
    #1 rst_a = 0;
    rst_b = 0;
    @(negedge clk);
    check("req_after_rst", bus_a.mem_req, 0);
    @(posedge clk);
    rmask = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rmask[c] = ret_a;
    end
    check("retire_cycles", rmask, 9'b1_0001_0000);
    @(negedge clk);
    check("pc_after_add", pc_a, 2);
    n = 0;
    while (!(bus_a.mem_req && bus_a.mem_we && bus_a.mem_addr == 16'h20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sw_seen", n < 100, 1);
    for (int k = 0; k < DWAIT + 1; k++) begin
      check("sw_stable", {bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata}, {2'b11, 16'h20, 16'd5});
      @(negedge clk);
    end
    n = 0;
    while (!(bus_a.mem_req && !bus_a.mem_we && bus_a.mem_addr == 16'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("lw_fetch_seen", n < 100, 1);
    lat = 1;
    while (!ret_a && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("lw_latency", lat, 8);
    n = 0;
    while (pc_a !== 16'd24 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_end_a", pc_a, 24);
    repeat (20) @(negedge clk);
    check("store_count_a", nlog_a, exp_a.size());
    check("store_count_b", nlog_b, exp_b.size());
    check("halted_b", halt_b, 0);
    for (int i = 0; i < 64 && exp_a.size() > 0; i++) begin
      ea = exp_a.pop_front();
      check("store_a", {log_addr_a[i], log_data_a[i]}, ea);
    end
    for (int i = 0; i < 64 && exp_b.size() > 0; i++) begin
      eb = exp_b.pop_front();
      check("store_b", {log_addr_b[i], log_data_b[i]}, eb);
    end
    rst_a = 1;
    imem_a[0] = lu(1, 'h3FF);
    imem_a[1] = ri(OP_ADDI, 1, 1, 63);
    imem_a[2] = rr(OP_JALR, 0, 1, 0);
    imem_a[16'hFFFF] = ri(OP_BEQ, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_a = 0;
    n = 0;
    while (pc_a !== 16'hFFFF && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_ffff", pc_a, 16'hFFFF);
    n = 0;
    while (!ret_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beq_wrap_retire", ret_a, 1);
    @(negedge clk);
    check("pc_wrap", pc_a, 0);
    rst_a = 1;
    imem_a[0] = ri(OP_SW, 0, 0, 'h20);
    imem_a[1] = HALT_INSTR;
    repeat (2) @(posedge clk);
    #1 rst_a = 0;
    n = 0;
    while (!(bus_a.mem_req && bus_a.mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sw_wait_seen", n < 100, 1);
    nsave = nlog_a;
    rst_a = 1;
    @(negedge clk);
    check("req_after_mem_rst", bus_a.mem_req, 0);
    check("pc_after_mem_rst", pc_a, 0);
    repeat (3) @(negedge clk);
    check("no_store_on_rst", nlog_a, nsave);
    @(posedge clk);
    #1 rst_a = 0;
    n = 0;
    while (!(pc_a == 16'd1 && ret_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("e071_retire", ret_a, 1);
    @(negedge clk);
`ifdef RISC16_HALT_EN
    check("halted_set", halt_a, 1);
    any_req = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_req = any_req | bus_a.mem_req;
    end
    check("no_req_halt", any_req, 0);
    check("pc_halt", pc_a, 1);
`else
    check("halted_tied", halt_a, 0);
    check("e071_jalr_pc", pc_a, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
